// File: rtl/pixel_ram_arbiter.sv
// pixel_ram_arbiter
// Round-robin share of the single 6x6x3 image RAM between several scan
// engines. One requester is granted per cycle; its (x,y) becomes the RAM
// address and the pixel comes back one cycle later with a per-requester
// valid strobe. Out-of-range coordinates are still granted, but they
// return rdata=0 with rerr=1.
module pixel_ram_arbiter #(
  parameter int N_REQ  = 3,
  parameter int XSZ    = 3,
  parameter int YSZ    = 3,
  parameter int ADDRSZ = 6,
  parameter int COLSZ  = 3,
  parameter int WIDTH  = 6,
  parameter int HEIGHT = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*XSZ-1:0]   req_x,
  input  logic [N_REQ*YSZ-1:0]   req_y,
  output logic [N_REQ-1:0]       gnt,
  output logic [ADDRSZ-1:0]      ram_address,
  input  logic [COLSZ-1:0]       ram_q,
  output logic [N_REQ-1:0]       rvalid,
  output logic [COLSZ-1:0]       rdata,
  output logic                   rerr,
  output logic                   busy
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Round-robin pointer: the index that has first claim this cycle.
  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   ptrNext;

  // Winner of this cycle's scan.
  logic              grantAny;
  logic [IDXW-1:0]   grantIdx;
  int                scanIdx;

  // Coordinates of the winner and the address derived from them.
  logic [XSZ-1:0]    selX;
  logic [YSZ-1:0]    selY;
  logic [ADDRSZ-1:0] linAddr;
  logic [ADDRSZ-1:0] lastAddr;
  logic              outOfRange;

  // Response pipeline stage: who was granted last cycle, and whether its
  // coordinate was invalid.
  logic [N_REQ-1:0]  rvalidQ;
  logic              oorQ;

  // Scan requesters starting at ptr, wrapping modulo N_REQ; first hit wins.
  // Reset blocks any grant so nothing is launched into the response stage.
  always_comb begin
    grantAny = 1'b0;
    grantIdx = '0;
    scanIdx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scanIdx = (int'(ptr) + k) % N_REQ;
      if (!grantAny && req[scanIdx]) begin
        grantAny = 1'b1;
        grantIdx = IDXW'(scanIdx);
      end
    end
    if (reset) begin
      grantAny = 1'b0;
    end
  end

  // One-hot grant from the winning index.
  always_comb begin
    gnt = '0;
    if (grantAny) begin
      gnt[grantIdx] = 1'b1;
    end
  end

  // Pick the winner's coordinates, build the linear address and range-check.
  always_comb begin
    selX       = req_x[grantIdx*XSZ +: XSZ];
    selY       = req_y[grantIdx*YSZ +: YSZ];
    linAddr    = ADDRSZ'(selY) * ADDRSZ'(WIDTH) + ADDRSZ'(selX);
    outOfRange = (int'(selX) >= WIDTH) || (int'(selY) >= HEIGHT);
  end

  // Pointer moves to the slot just after the winner.
  always_comb begin
    if (int'(grantIdx) == N_REQ - 1) begin
      ptrNext = '0;
    end else begin
      ptrNext = grantIdx + IDXW'(1);
    end
  end

  // The RAM address port keeps its previous value on idle cycles so the
  // RAM input does not toggle needlessly.
  always_comb begin
    ram_address = grantAny ? linAddr : lastAddr;
  end

  // Arbitration state and the one-deep response pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      lastAddr <= '0;
      rvalidQ  <= '0;
      oorQ     <= 1'b0;
    end else begin
      if (grantAny) begin
        ptr      <= ptrNext;
        lastAddr <= linAddr;
      end
      rvalidQ <= gnt;
      oorQ    <= grantAny & outOfRange;
    end
  end

  // Response outputs. A response launched in the cycle before a reset is
  // masked while reset is high, so it never reaches a requester.
  always_comb begin
    rvalid = reset ? '0 : rvalidQ;
    busy   = |rvalid;
    rerr   = busy & oorQ;
    rdata  = (busy && !oorQ) ? ram_q : '0;
  end

endmodule
